// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline stage: valid/ready register with an optional skid entry,
// synchronous flush and bubble insertion (control field zeroed on capture).
module pipe_stage_elastic #(
  parameter int unsigned DATA_W  = 192,
  parameter int unsigned CTRL_W  = 24,
  parameter int unsigned SKID_EN = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              bubble,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy
);

  localparam int unsigned OCC_W = 2;
  localparam bit          HAS_SKID = (SKID_EN != 0);

  logic              m_valid_q, m_valid_d;
  logic [DATA_W-1:0] m_data_q,  m_data_d;
  logic [CTRL_W-1:0] m_ctrl_q,  m_ctrl_d;
  logic              s_valid_q, s_valid_d;
  logic [DATA_W-1:0] s_data_q,  s_data_d;
  logic [CTRL_W-1:0] s_ctrl_q,  s_ctrl_d;

  logic              in_fire_c;
  logic              out_fire_c;
  logic [CTRL_W-1:0] in_ctrl_c;

  // Skid variant keeps in_ready purely registered-state based.
  always_comb begin
    if (HAS_SKID) begin
      in_ready = rst & ~flush & ~s_valid_q;
    end else begin
      in_ready = rst & ~flush & (~m_valid_q | out_ready);
    end
  end

  assign in_fire_c  = in_valid & in_ready;
  assign out_fire_c = m_valid_q & out_ready;
  assign in_ctrl_c  = bubble ? '0 : in_ctrl;

  assign out_valid = m_valid_q;
  assign out_data  = m_data_q;
  assign out_ctrl  = m_ctrl_q;
  assign occupancy = OCC_W'(m_valid_q) + OCC_W'(s_valid_q);

  // Next-state: entries that become invalid are zeroed so idle registers read 0.
  always_comb begin
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_ctrl_d  = m_ctrl_q;
    s_valid_d = s_valid_q;
    s_data_d  = s_data_q;
    s_ctrl_d  = s_ctrl_q;

    if (flush) begin
      m_valid_d = 1'b0;
      m_data_d  = '0;
      m_ctrl_d  = '0;
      s_valid_d = 1'b0;
      s_data_d  = '0;
      s_ctrl_d  = '0;
    end else if (HAS_SKID) begin
      if (!m_valid_q) begin
        if (in_fire_c) begin
          m_valid_d = 1'b1;
          m_data_d  = in_data;
          m_ctrl_d  = in_ctrl_c;
        end
      end else if (!s_valid_q) begin
        if (in_fire_c && out_fire_c) begin
          m_data_d = in_data;
          m_ctrl_d = in_ctrl_c;
        end else if (in_fire_c) begin
          s_valid_d = 1'b1;
          s_data_d  = in_data;
          s_ctrl_d  = in_ctrl_c;
        end else if (out_fire_c) begin
          m_valid_d = 1'b0;
          m_data_d  = '0;
          m_ctrl_d  = '0;
        end
      end else if (out_fire_c) begin
        m_data_d  = s_data_q;
        m_ctrl_d  = s_ctrl_q;
        s_valid_d = 1'b0;
        s_data_d  = '0;
        s_ctrl_d  = '0;
      end
    end else begin
      if (in_fire_c) begin
        m_valid_d = 1'b1;
        m_data_d  = in_data;
        m_ctrl_d  = in_ctrl_c;
      end else if (out_fire_c) begin
        m_valid_d = 1'b0;
        m_data_d  = '0;
        m_ctrl_d  = '0;
      end
    end

    if (!HAS_SKID) begin
      s_valid_d = 1'b0;
      s_data_d  = '0;
      s_ctrl_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_ctrl_q  <= '0;
      s_valid_q <= 1'b0;
      s_data_q  <= '0;
      s_ctrl_q  <= '0;
    end else begin
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_ctrl_q  <= m_ctrl_d;
      s_valid_q <= s_valid_d;
      s_data_q  <= s_data_d;
      s_ctrl_q  <= s_ctrl_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Scoreboard bench for pipe_stage_elastic (SKID_EN=1): directed stimulus
// pushes expected entries, an independent monitor pops on every out_fire.
module tb_pipe_stage_elastic;

  localparam int unsigned DATA_W = 192;
  localparam int unsigned CTRL_W = 24;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [CTRL_W-1:0] ctrl;
  } entry_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic              bubble;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;
  logic [1:0]        occupancy;

  int checks = 0;
  int errors = 0;
  entry_t exp_q[$];

  pipe_stage_elastic #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .SKID_EN(1)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
    .bubble(bubble), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Monitor: compare every delivered head against the scoreboard front.
  always @(negedge clk) begin
    if (rst === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_out: got data %0h ctrl %0h expected nothing", out_data, out_ctrl);
      end else begin
        entry_t e;
        e = exp_q.pop_front();
        if (out_data !== e.data || out_ctrl !== e.ctrl) begin
          errors++;
          $display("FAIL out_entry: got %0h/%0h expected %0h/%0h", out_data, out_ctrl, e.data, e.ctrl);
        end
      end
    end
  end

  // Offer one entry; push its expected image on the cycle it is accepted.
  task automatic send(input logic [DATA_W-1:0] d, input logic [CTRL_W-1:0] c, input logic b);
    bit fired = 0;
    entry_t e;
    in_valid = 1'b1; in_data = d; in_ctrl = c; bubble = b;
    for (int n = 0; n < 50 && !fired; n++) begin
      @(negedge clk);
      if (in_ready === 1'b1) begin
        fired = 1;
        e.data = d;
        e.ctrl = b ? '0 : c;
        exp_q.push_back(e);
      end
      @(posedge clk); #1;
    end
    if (!fired) chk("send_timeout", 0, 1);
  endtask

  task automatic idle();
    in_valid = 1'b0; bubble = 1'b0; in_data = '0; in_ctrl = '0;
  endtask

  task automatic drain();
    for (int n = 0; n < 20 && exp_q.size() != 0; n++) @(posedge clk);
    #1;
    chk("drain_empty", DATA_W'(exp_q.size()), 0);
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; out_ready = 1'b0;
    in_valid = 1'b1; in_data = DATA_W'(32'hDEAD); in_ctrl = CTRL_W'(7); bubble = 1'b0;

    // Reset and first accept
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", DATA_W'(out_valid), 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_in_ready", DATA_W'(in_ready), 0);
    chk("rst_occupancy", DATA_W'(occupancy), 0);
    @(posedge clk); #1;
    rst = 1'b1; out_ready = 1'b1;
    in_data = DATA_W'(16'h1234); in_ctrl = CTRL_W'(5);
    @(negedge clk);
    chk("first_in_ready", DATA_W'(in_ready), 1);
    exp_q.push_back('{data: DATA_W'(16'h1234), ctrl: CTRL_W'(5)});
    @(posedge clk); #1;
    chk("first_out_valid", DATA_W'(out_valid), 1);
    chk("first_out_data", out_data, DATA_W'(16'h1234));
    chk("first_out_ctrl", DATA_W'(out_ctrl), 5);
    idle();
    drain();

    // Streaming 1..8 with out_ready=1
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1; in_data = DATA_W'(i); in_ctrl = CTRL_W'(i + 16); bubble = 1'b0;
      @(negedge clk);
      chk("stream_in_ready", DATA_W'(in_ready), 1);
      if (i > 1) begin
        chk("stream_occupancy", DATA_W'(occupancy), 1);
        chk("stream_out_valid", DATA_W'(out_valid), 1);
      end
      exp_q.push_back('{data: DATA_W'(i), ctrl: CTRL_W'(i + 16)});
      @(posedge clk); #1;
    end
    idle();
    drain();

    // Backpressure into skid
    out_ready = 1'b0;
    send(DATA_W'(8'hA), CTRL_W'(1), 1'b0);
    send(DATA_W'(8'hB), CTRL_W'(2), 1'b0);
    in_valid = 1'b1; in_data = DATA_W'(8'hC); in_ctrl = CTRL_W'(3);
    repeat (2) begin
      @(negedge clk);
      chk("bp_occupancy", DATA_W'(occupancy), 2);
      chk("bp_in_ready", DATA_W'(in_ready), 0);
      chk("bp_head_stable", out_data, DATA_W'(8'hA));
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    send(DATA_W'(8'hC), CTRL_W'(3), 1'b0);
    idle();
    drain();

    // Bubble zeroes control, keeps payload
    send(DATA_W'(8'h40), CTRL_W'(24'hFFFFFF), 1'b1);
    idle();
    chk("bubble_out_data", out_data, DATA_W'(8'h40));
    chk("bubble_out_ctrl", DATA_W'(out_ctrl), 0);
    drain();

    // Flush with full stage
    out_ready = 1'b0;
    send(DATA_W'(8'h11), CTRL_W'(1), 1'b0);
    send(DATA_W'(8'h22), CTRL_W'(2), 1'b0);
    in_valid = 1'b1; in_data = DATA_W'(8'h99); in_ctrl = CTRL_W'(9); flush = 1'b1;
    @(negedge clk);
    chk("flush_occ_before", DATA_W'(occupancy), 2);
    chk("flush_in_ready", DATA_W'(in_ready), 0);
    @(posedge clk); #1;
    flush = 1'b0; idle();
    exp_q.delete();
    chk("flush_out_valid", DATA_W'(out_valid), 0);
    chk("flush_occupancy", DATA_W'(occupancy), 0);
    chk("flush_out_data", out_data, 0);
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    // Asynchronous reset mid-stream
    out_ready = 1'b0;
    send(DATA_W'(8'h55), CTRL_W'(5), 1'b0);
    send(DATA_W'(8'h66), CTRL_W'(6), 1'b0);
    idle();
    @(negedge clk);
    chk("arst_occ_before", DATA_W'(occupancy), 2);
    #2 rst = 1'b0;
    #1;
    chk("arst_out_valid", DATA_W'(out_valid), 0);
    chk("arst_occupancy", DATA_W'(occupancy), 0);
    chk("arst_in_ready", DATA_W'(in_ready), 0);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    chk("post_arst_occupancy", DATA_W'(occupancy), 0);
    chk("post_arst_in_ready", DATA_W'(in_ready), 1);
    chk("post_arst_out_data", out_data, 0);
    repeat (3) @(posedge clk);
    send(DATA_W'(8'h77), CTRL_W'(7), 1'b0);
    idle();
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
